// File: rtl/micb_multi_ctrl.sv
// Multi-channel MICB bias controller: per-channel sync + debounce, shared
// fixed-priority arbiter that applies one power change, settles, then pulses Go.
module micb_multi_ctrl #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned SETTLE_CYC   = 50000
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [NUM_CH-1:0] Key_in,
    input  logic [NUM_CH-1:0] Mode,
    output logic [NUM_CH-1:0] MICB_Power,
    output logic [NUM_CH-1:0] Led,
    output logic              Go,
    output logic [NUM_CH-1:0] Go_ch,
    output logic              Busy
);

    localparam int unsigned DW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, APPLY, SETTLE, GO} state_t;

    state_t            state;
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] deb;
    logic [NUM_CH-1:0] deb_d;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] event_v;
    logic [NUM_CH-1:0] clear_v;
    logic [DW-1:0]     db_cnt [NUM_CH];
    logic [SW-1:0]     settle_cnt;
    logic [CW-1:0]     sel;
    logic [CW-1:0]     low_idx;
    logic              any_pending;
    logic              found;
    logic              new_bit;

    // Synchronisers and debouncers; released (1) is the reset level.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            deb_d <= '1;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= Key_in;
            sync2 <= sync1;
            deb_d <= deb;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press (1->0) always counts; release only in follow mode.
    always_comb begin
        event_v = (deb_d & ~deb) | (Mode & ~deb_d & deb);
    end

    always_comb begin
        low_idx     = '0;
        found       = 1'b0;
        any_pending = |pending;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pending[i] && !found) begin
                low_idx = CW'(i);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        clear_v = '0;
        if (state == APPLY) begin
            clear_v[sel] = 1'b1;
        end
        new_bit = Mode[sel] ? ~deb[sel] : ~MICB_Power[sel];
    end

    // Go/Go_ch are registered from the GO state, so they appear the cycle after it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            settle_cnt <= '0;
            pending    <= '0;
            MICB_Power <= '0;
            Led        <= '0;
            Go         <= 1'b0;
            Go_ch      <= '0;
            Busy       <= 1'b0;
        end else begin
            pending <= (pending & ~clear_v) | event_v;
            Go      <= 1'b0;
            Go_ch   <= '0;
            case (state)
                IDLE: begin
                    if (any_pending) begin
                        sel   <= low_idx;
                        Busy  <= 1'b1;
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    MICB_Power[sel] <= new_bit;
                    Led[sel]        <= new_bit;
                    settle_cnt      <= SET_LAST;
                    state           <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= GO;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                GO: begin
                    Go    <= 1'b1;
                    Go_ch <= NUM_CH'(1) << sel;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/micb_multi_ctrl.md
# micb_multi_ctrl

Parametrised multi-channel microphone-bias power controller for the audio front end. Each channel takes a raw push-button, debounces it internally, and turns the channel's MICB power enable on or off. One shared arbiter applies changes one channel at a time. It waits a programmable bias-settling interval after each change, then issues a one-cycle `Go` pulse, tagged with the channel, to start the downstream codec/ADC path.

## Interface
- NUM_CH, 2, number of independent bias channels (1..8)
- DEBOUNCE_CYC, 1000000, stable-level cycles required to accept a key change (20 ms at 50 MHz); ≥2
- SETTLE_CYC, 50000, bias settling wait in cycles between power change and Go; ≥1
- Clk  in  1  system clock
- Rst_n  in  1  reset, asynchronous, active-low; clock Clk
- Key_in  in  NUM_CH  raw buttons, active-low (0 = pressed), asynchronous to Clk
- Mode  in  NUM_CH  per-channel mode: 0 = toggle on press, 1 = follow (power on while held); sampled at APPLY
- MICB_Power  out  NUM_CH  bias enable per channel
- Led  out  NUM_CH  status LED per channel; registered copy of MICB_Power (same cycle)
- Go  out  1  one-cycle pulse after settling completes
- Go_ch  out  NUM_CH  one-hot channel serviced; valid only while Go=1, else 0
- Busy  out  1  high whenever arbiter not IDLE

## Operation
- Reset values: MICB_Power=0, Led=0, Go=0, Go_ch=0, Busy=0. Synchronisers and debounced levels reset to 1 (released). Counters and pending bits reset to 0. FSM resets to IDLE.
- Per channel: 2-FF synchroniser, then debouncer. The counter clears whenever the synced value equals the debounced level or changes. When the synced value has differed from the debounced level for DEBOUNCE_CYC consecutive cycles, the debounced level takes the synced value and the counter clears.
- Event generation:
  - Toggle mode: a debounced 1→0 edge (press) is an event. Releases are ignored.
  - Follow mode: both debounced edges are events.
- Event sets pending[i] in the cycle after the debounced change. Pending is a sticky single bit. Multiple events before service merge into one.
- FSM states:
  - IDLE: if any pending bit is set, latch sel = lowest-index pending channel, go to APPLY.
  - APPLY (1 cycle): clear pending[sel]. If Mode[sel]=0, invert MICB_Power[sel]. If Mode[sel]=1, set MICB_Power[sel] = ~debounced[sel] (pressed = on). Load the settle counter. Go to SETTLE.
  - SETTLE: count SETTLE_CYC cycles, then go to GO.
  - GO (1 cycle): Go=1, Go_ch=1<<sel. Return to IDLE.
- An event arriving on channel sel during APPLY is not lost. If it arrives in the same cycle as the clear, the set wins. It is serviced in a later pass.
- Other channels' MICB_Power never change while one channel is in service.
- Fixed priority: lower index wins whenever several bits are pending in IDLE.
- Counter widths come from $clog2 of each parameter. Counters never wrap past their terminal value.

## Timing
- Key to debounced level: 2 (sync) + DEBOUNCE_CYC cycles after the raw input settles. Glitches shorter than DEBOUNCE_CYC produce no event.
- Debounced change → pending: +1 cycle. Pending → APPLY: +1 cycle (IDLE decision).
- MICB_Power and Led change on the clock edge that leaves APPLY.
- Go is high exactly SETTLE_CYC+1 cycles after MICB_Power changes, for exactly one cycle.
- Busy rises with APPLY and falls when IDLE is re-entered after GO.
- Back-to-back services: the minimum spacing between Go pulses is SETTLE_CYC+3 cycles.
- Rst_n assertion at any time, including mid-SETTLE, clears all state immediately. No Go is issued for the aborted service, and the pending event is dropped.

## Test plan
- Reset: hold Rst_n=0 with keys pressed → all outputs 0. Release reset with keys held → no event until a genuine debounced press edge occurs, because debounced levels reset to released. Use DEBOUNCE_CYC=8, SETTLE_CYC=4.
- Bouncy toggle: ch0 key with 3-cycle glitches, then held low for 20 cycles.
  - Expected: exactly one event, MICB_Power=01, Led=01.
  - Go=1 with Go_ch=01 exactly 5 cycles after the power change.
  - Second press → MICB_Power=00 and a second Go.
- Simultaneous: ch0 and ch1 debounced presses in the same cycle.
  - Expected: ch0 serviced first (Go_ch=01), then ch1 (Go_ch=10).
  - Pulses spaced 7 cycles apart; final MICB_Power=11.
- Follow mode: Mode[1]=1; press ch1 for 30 cycles, then release.
  - Expected: MICB_Power[1]=1 after the press, 0 after the release.
  - Two Go pulses with Go_ch=10.
- Re-press during service: ch0 press, then another debounced ch0 press while in SETTLE.
  - Expected: first toggle to 1, Go, then second toggle back to 0, then second Go.
- Reset mid-SETTLE: Rst_n low for 2 cycles during SETTLE.
  - Expected: MICB_Power=0, Busy=0, no Go pulse afterwards.
